// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with stall/flush, invalid-instruction gating and a stall-time
// forward capture buffer. Define EXE_MEM_STAT_EN to add saturating stall/bubble counters.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5
`ifdef EXE_MEM_STAT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [1:0]        st_val_sel,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic              valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic [DEST_W-1:0] dest
`ifdef EXE_MEM_STAT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic              valid_q, valid_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] st_val_q, st_val_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] cap_val_q, cap_val_d;
    logic              cap_vld_q, cap_vld_d;
    logic [DATA_W-1:0] fwd_mux;
    logic [DATA_W-1:0] eff_st;

    always_comb begin
        case (st_val_sel)
            2'b01:   fwd_mux = mem_fwd_val;
            2'b10:   fwd_mux = wb_fwd_val;
            default: fwd_mux = st_val_in;
        endcase
    end

    // A value captured during a stall takes precedence over whatever the bypass shows at load time.
    assign eff_st = cap_vld_q ? cap_val_q : fwd_mux;

    always_comb begin
        valid_d      = valid_q;
        wb_en_d      = wb_en_q;
        mem_r_en_d   = mem_r_en_q;
        mem_w_en_d   = mem_w_en_q;
        pc_d         = pc_q;
        alu_result_d = alu_result_q;
        st_val_d     = st_val_q;
        dest_d       = dest_q;
        cap_val_d    = cap_val_q;
        cap_vld_d    = cap_vld_q;
        if (flush) begin
            valid_d      = 1'b0;
            wb_en_d      = 1'b0;
            mem_r_en_d   = 1'b0;
            mem_w_en_d   = 1'b0;
            pc_d         = '0;
            alu_result_d = '0;
            st_val_d     = '0;
            dest_d       = '0;
            cap_vld_d    = 1'b0;
        end else if (hold) begin
            if (!cap_vld_q && (st_val_sel == 2'b01 || st_val_sel == 2'b10)) begin
                cap_val_d = fwd_mux;
                cap_vld_d = 1'b1;
            end
        end else begin
            valid_d      = valid_in;
            wb_en_d      = wb_en_in & valid_in;
            mem_r_en_d   = mem_r_en_in & valid_in;
            mem_w_en_d   = mem_w_en_in & valid_in;
            pc_d         = pc_in;
            alu_result_d = alu_result_in;
            st_val_d     = eff_st;
            dest_d       = dest_in;
            cap_vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            pc_q         <= '0;
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_q       <= '0;
            cap_val_q    <= '0;
            cap_vld_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            pc_q         <= pc_d;
            alu_result_q <= alu_result_d;
            st_val_q     <= st_val_d;
            dest_q       <= dest_d;
            cap_val_q    <= cap_val_d;
            cap_vld_q    <= cap_vld_d;
        end
    end

    assign valid      = valid_q;
    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign pc         = pc_q;
    assign alu_result = alu_result_q;
    assign st_val     = st_val_q;
    assign dest       = dest_q;

`ifdef EXE_MEM_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // A bubble is either an explicit flush or a load of an empty slot; both counters stick at all-ones.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hold && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((flush || (!hold && !valid_in)) && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg: directed scenarios plus randomized traffic
// compared against a rule-level reference model (counters checked when EXE_MEM_STAT_EN is defined).
module tb_exe_mem_pipe_reg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEST_W = 5;
`ifdef EXE_MEM_STAT_EN
    localparam int CNT_W  = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              hold, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] alu_result_in, st_val_in, mem_fwd_val, wb_fwd_val;
    logic [DEST_W-1:0] dest_in;
    logic [1:0]        st_val_sel;
    logic              valid, wb_en, mem_r_en, mem_w_en;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu_result, st_val;
    logic [DEST_W-1:0] dest;
`ifdef EXE_MEM_STAT_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: what the stage should be presenting, plus the pending stall capture.
    logic              mValid, mWb, mMr, mMw;
    logic [PC_W-1:0]   mPc;
    logic [DATA_W-1:0] mAlu, mSt, mCapVal;
    logic [DEST_W-1:0] mDest;
    logic              mCapVld;
    int                mStall, mBubble;

    exe_mem_pipe_reg #(
        .DATA_W(DATA_W),
        .PC_W(PC_W),
        .DEST_W(DEST_W)
`ifdef EXE_MEM_STAT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .hold(hold),
        .flush(flush),
        .valid_in(valid_in),
        .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in),
        .pc_in(pc_in),
        .alu_result_in(alu_result_in),
        .st_val_in(st_val_in),
        .dest_in(dest_in),
        .st_val_sel(st_val_sel),
        .mem_fwd_val(mem_fwd_val),
        .wb_fwd_val(wb_fwd_val),
        .valid(valid),
        .wb_en(wb_en),
        .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en),
        .pc(pc),
        .alu_result(alu_result),
        .st_val(st_val),
        .dest(dest)
`ifdef EXE_MEM_STAT_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] selectedStore(input logic [1:0] sel);
        if (sel == 2'd1) return mem_fwd_val;
        if (sel == 2'd2) return wb_fwd_val;
        return st_val_in;
    endfunction

    task automatic modelReset();
        {mValid, mWb, mMr, mMw} = 4'b0;
        mPc = '0; mAlu = '0; mSt = '0; mDest = '0;
        mCapVal = '0; mCapVld = 1'b0;
        mStall = 0; mBubble = 0;
    endtask

    // One rising edge worth of the stage's rules, applied to the inputs present at that edge.
    task automatic modelEdge();
`ifdef EXE_MEM_STAT_EN
        int maxCnt = (1 << CNT_W) - 1;
        if (hold && !flush && mStall < maxCnt) mStall++;
        if ((flush || (!hold && !valid_in)) && mBubble < maxCnt) mBubble++;
`endif
        if (flush) begin
            {mValid, mWb, mMr, mMw} = 4'b0;
            mPc = '0; mAlu = '0; mSt = '0; mDest = '0;
            mCapVld = 1'b0;
        end else if (hold) begin
            if (!mCapVld && (st_val_sel == 2'd1 || st_val_sel == 2'd2)) begin
                mCapVal = selectedStore(st_val_sel);
                mCapVld = 1'b1;
            end
        end else begin
            mValid = valid_in;
            mWb    = valid_in && wb_en_in;
            mMr    = valid_in && mem_r_en_in;
            mMw    = valid_in && mem_w_en_in;
            mPc    = pc_in;
            mAlu   = alu_result_in;
            mDest  = dest_in;
            mSt    = mCapVld ? mCapVal : selectedStore(st_val_sel);
            mCapVld = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 64'(valid), 64'(mValid));
        checkOutput({tag, ".wb_en"}, 64'(wb_en), 64'(mWb));
        checkOutput({tag, ".mem_r_en"}, 64'(mem_r_en), 64'(mMr));
        checkOutput({tag, ".mem_w_en"}, 64'(mem_w_en), 64'(mMw));
        checkOutput({tag, ".pc"}, 64'(pc), 64'(mPc));
        checkOutput({tag, ".alu_result"}, 64'(alu_result), 64'(mAlu));
        checkOutput({tag, ".st_val"}, 64'(st_val), 64'(mSt));
        checkOutput({tag, ".dest"}, 64'(dest), 64'(mDest));
`ifdef EXE_MEM_STAT_EN
        checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(mStall));
        checkOutput({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(mBubble));
`endif
    endtask

    // Advance one clock with the currently driven inputs, then compare just after the edge.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic setLoad(input logic v, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] a,
                           input logic [DEST_W-1:0] d, input logic [1:0] sel, input logic [DATA_W-1:0] sv);
        hold = 1'b0; flush = 1'b0; valid_in = v;
        pc_in = p; alu_result_in = a; dest_in = d; st_val_sel = sel; st_val_in = sv;
    endtask

    initial begin
        rst = 1'b0;
        {hold, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in} = 6'b0;
        pc_in = '0; alu_result_in = '0; st_val_in = '0; dest_in = '0;
        st_val_sel = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic load with one-cycle latency.
        setLoad(1'b1, 32'h40, 32'h1234, 5'd7, 2'b00, 32'hAA);
        wb_en_in = 1'b1;
        applyStimulus("load");
        checkOutput("load.pc_const", 64'(pc), 64'h40);
        checkOutput("load.st_const", 64'(st_val), 64'hAA);
        checkOutput("load.wb_const", 64'(wb_en), 64'h1);

        // Asynchronous reset must clear outputs before the next edge.
        #3 rst = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        checkOutput("async_reset.pc_const", 64'(pc), 64'h0);
        #1 rst = 1'b1;
        wb_en_in = 1'b0;

        // Forwarding selects, including the reserved encoding.
        setLoad(1'b1, 32'h44, 32'h1, 5'd1, 2'b01, 32'hDEAD); mem_fwd_val = 32'h55;
        applyStimulus("fwd_mem");
        checkOutput("fwd_mem.const", 64'(st_val), 64'h55);
        setLoad(1'b1, 32'h48, 32'h2, 5'd2, 2'b10, 32'hDEAD); wb_fwd_val = 32'h66;
        applyStimulus("fwd_wb");
        checkOutput("fwd_wb.const", 64'(st_val), 64'h66);
        setLoad(1'b1, 32'h4C, 32'h3, 5'd3, 2'b11, 32'h77);
        applyStimulus("fwd_rsvd");
        checkOutput("fwd_rsvd.const", 64'(st_val), 64'h77);

        // Stall capture: first captured value survives a changing bypass.
        hold = 1'b1; st_val_sel = 2'b10; wb_fwd_val = 32'h99; pc_in = 32'h80; st_val_in = 32'h0;
        applyStimulus("hold1");
        wb_fwd_val = 32'h11;
        applyStimulus("hold2");
        checkOutput("hold2.pc_kept", 64'(pc), 64'h4C);
        hold = 1'b0;
        applyStimulus("hold_release");
        checkOutput("hold_release.captured", 64'(st_val), 64'h99);

        // Reset in the middle of a hold drops the capture.
        hold = 1'b1; st_val_sel = 2'b01; mem_fwd_val = 32'hC0DE;
        applyStimulus("hold_pre_reset");
        @(negedge clk);
        rst = 1'b0; #1; modelReset(); #1 rst = 1'b1;
        setLoad(1'b1, 32'h90, 32'h9, 5'd9, 2'b00, 32'hBEEF);
        applyStimulus("post_reset_load");
        checkOutput("post_reset_load.st_const", 64'(st_val), 64'hBEEF);

        // Flush wins over hold and clears a pending capture.
        hold = 1'b1; st_val_sel = 2'b10; wb_fwd_val = 32'h1357;
        applyStimulus("cap_before_flush");
        flush = 1'b1; valid_in = 1'b1; mem_w_en_in = 1'b1;
        applyStimulus("flush_hold");
        checkOutput("flush_hold.mem_w_en", 64'(mem_w_en), 64'h0);
        flush = 1'b0; hold = 1'b0; st_val_sel = 2'b00; st_val_in = 32'h2468;
        applyStimulus("after_flush");
        checkOutput("after_flush.st_const", 64'(st_val), 64'h2468);

        // Invalid instruction gates controls but still loads fields.
        setLoad(1'b0, 32'hA0, 32'hFACE, 5'd4, 2'b00, 32'h5);
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
        applyStimulus("invalid");
        checkOutput("invalid.wb_en", 64'(wb_en), 64'h0);
        checkOutput("invalid.alu_const", 64'(alu_result), 64'hFACE);

`ifdef EXE_MEM_STAT_EN
        // Counter saturation from a fresh reset.
        @(negedge clk);
        rst = 1'b0; #1; modelReset(); #1 rst = 1'b1;
        hold = 1'b1; flush = 1'b0; valid_in = 1'b1; st_val_sel = 2'b00;
        for (int i = 0; i < 5; i++) applyStimulus("stat_hold");
        checkOutput("stat.stall_sat", 64'(stall_cnt), 64'h3);
        flush = 1'b1;
        applyStimulus("stat_flush");
        flush = 1'b0; hold = 1'b0; valid_in = 1'b0;
        applyStimulus("stat_invalid");
        checkOutput("stat.bubble", 64'(bubble_cnt), 64'h2);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            hold          = ($urandom_range(0, 99) < 35);
            flush         = ($urandom_range(0, 99) < 8);
            valid_in      = ($urandom_range(0, 99) < 80);
            wb_en_in      = 1'($urandom);
            mem_r_en_in   = 1'($urandom);
            mem_w_en_in   = 1'($urandom);
            pc_in         = $urandom;
            alu_result_in = $urandom;
            st_val_in     = $urandom;
            dest_in       = DEST_W'($urandom);
            st_val_sel    = 2'($urandom);
            mem_fwd_val   = $urandom;
            wb_fwd_val    = $urandom;
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
